alu_decoder: RTL and testbench
==============================

# alu_decoder

Registered decode stage that turns a 32-bit RV32I instruction into ALU control: the 5-bit `alu_mode`, operand selects and a sign-extended immediate. It is the producer side of the ALU's `alu_mode`/operand interface. It sits between fetch and execute, with valid/ready handshakes on both sides and a flush input.

## Interface
- `WordSize`, 32, datapath width; immediates and the PC are sign/zero-extended to this width.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all held and incoming instructions.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_instr` in 32: instruction word.
- `in_pc` in WordSize: instruction PC.
- `out_valid` in→out 1 (output), `out_ready` in 1: downstream handshake.
- `out_alu_mode` out 5: ALU opcode (ADD 00, SUB 10, XOR 04, OR 06, AND 07, LLS 01, LRS 05, ARS 15, SSLT 02, USLT 03).
- `out_a_sel` out 2: 0 = rs1, 1 = pc, 2 = zero.
- `out_b_sel` out 1: 0 = rs2, 1 = imm.
- `out_imm` out WordSize: sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each.
- `out_rd_we` out 1: register write enable.
- `out_illegal` out 1: instruction not decodable.
- `out_pc` out WordSize: PC passed through.

## Operation
- **OP (0110011):** mode = {f7[5], 0, f3}; a = rs1, b = rs2. f7 must be 0x00, or 0x20 only with f3 ∈ {000, 101}; otherwise the instruction is illegal.
- **OP-IMM (0010011):** mode = {0, 0, f3}, except f3 = 101 gives {f7[5], 0, 101}; a = rs1, b = imm(I).
  - Shifts (f3 001/101) require f7 ∈ {0x00, 0x20 for 101 only}; anything else is illegal.
- **LUI:** ADD, a = zero, b = imm(U).
- **AUIPC:** ADD, a = pc, b = imm(U).
- **JAL:** ADD, a = pc, b = imm(J).
- **JALR:** ADD, a = rs1, b = imm(I).
- **LOAD:** ADD, a = rs1, b = imm(I).
- **STORE:** ADD, a = rs1, b = imm(S); rd_we = 0.
- **BRANCH:** a = rs1, b = rs2, out_imm = imm(B), rd_we = 0.
  - BEQ/BNE → SUB; BLT/BGE → SSLT; BLTU/BGEU → USLT.
  - f3 010/011 are illegal.
- **rd_we:** 1 for all register-writing formats, including rd = 0.
- **Illegal instructions:** unknown opcode, or any rule above violated.
  - Still handed downstream with out_illegal = 1, mode = ADD, rd_we = 0, sels = 0, imm = 0.
- **Immediates:** U = {instr[31:12], 12'b0}; all others are sign-extended from instr[31], per the RV32I bit layout.

## Timing
- Latency: 1 cycle from the accepting edge (in_valid & in_ready) to out_valid.
- Throughput: 1 instruction per cycle when out_ready is held high.
- A transfer out occurs on out_valid & out_ready.
- While out_valid & !out_ready, all out_* signals stay stable.
- Reset state:
  - out_valid = 0, and every out_* data field = 0.
  - in_ready = 1 in skid mode; in non-skid mode it follows its combinational equation.
- Flush has priority over everything else:
  - On that edge all entries are invalidated.
  - An in_valid beat presented in the same cycle is dropped.
  - out_valid = 0 in the next cycle; in_ready = 1 in the next cycle.
- Accept and drain in the same cycle with one entry held: the new entry replaces it, and out_valid stays 1.
- Order is strictly preserved; no instruction is duplicated or lost except by flush.

## Configuration
- `ALU_DECODER_SKID_EN` defined: a two-entry skid buffer (output register plus skid register).
  - in_ready is a flop output equal to !skid_full, so there is no ready combinational path.
  - The skid register fills when the output is stalled and a beat is accepted.
  - On the next out transfer, the skid entry moves to the output.
- Undefined: a single output register, with in_ready = !out_valid | out_ready (combinational from out_ready).
- Functional sequence is identical in both modes; only in_ready timing differs.

## Structure
- Package `alu_pkg` holds:
  - the ALU opcode constants (moved out of global scope);
  - RV32I major opcode constants;
  - `a_sel_t` enum (RS1, PC, ZERO);
  - packed struct `dec_t` with fields mode, a_sel, b_sel, imm, rs1, rs2, rd, rd_we, illegal, pc.
- Sub-module `alu_instr_decode`:
  - purely combinational, mapping instr and pc to `dec_t`;
  - `alu_decoder` instantiates it and implements the handshake buffering around `dec_t`.

## Test plan
- **ADD/SUB decode:** `add x3,x1,x2` (0x002081B3), then `sub` (0x402081B3), with out_ready = 1. Each appears one cycle after acceptance with mode 00, then 10; rs1 = 1, rs2 = 2, rd = 3, b_sel = 0.
- **Immediate and shift decode:**
  - `srai x5,x6,3` (0x40335293) gives mode 15, imm = 3, b_sel = 1.
  - `addi x1,x0,-1` (0xFFF00093) gives imm = 0xFFFFFFFF.
  - `lui x1,0x12345` gives imm = 0x12345000, a_sel = 2.
- **Branches and illegal encodings:**
  - `bltu` gives mode 03, rd_we = 0, B imm correct for offset −8 (0xFFFFFFF8).
  - f3 = 010 on BRANCH gives out_illegal = 1, mode = 00.
  - opcode 0x7F gives out_illegal = 1.
- **Backpressure:** four back-to-back beats with out_ready = 0 for 3 cycles.
  - In skid mode, in_ready drops after 2 accepts.
  - Outputs stay stable during the stall.
  - All 4 instructions emerge in order with no loss.
- **Flush:** assert flush while both entries are full and in_valid = 1. Next cycle out_valid = 0 and in_ready = 1; the dropped beat never appears.
- **Reset mid-stream:** deassert rstn asynchronously while out_valid = 1. out_valid falls immediately without waiting for a clock edge; all out_* = 0; operation resumes cleanly after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU decode types: ALU opcodes, RV32I major opcodes, operand selects and the decoded payload.
package alu_pkg;

    localparam int unsigned WordSize = 32;
    localparam int unsigned ModeW    = 5;
    localparam int unsigned RegW     = 5;

    localparam logic [ModeW-1:0] ALU_ADD  = 5'h00;
    localparam logic [ModeW-1:0] ALU_SUB  = 5'h10;
    localparam logic [ModeW-1:0] ALU_XOR  = 5'h04;
    localparam logic [ModeW-1:0] ALU_OR   = 5'h06;
    localparam logic [ModeW-1:0] ALU_AND  = 5'h07;
    localparam logic [ModeW-1:0] ALU_LLS  = 5'h01;
    localparam logic [ModeW-1:0] ALU_LRS  = 5'h05;
    localparam logic [ModeW-1:0] ALU_ARS  = 5'h15;
    localparam logic [ModeW-1:0] ALU_SSLT = 5'h02;
    localparam logic [ModeW-1:0] ALU_USLT = 5'h03;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    typedef struct packed {
        logic [ModeW-1:0]    mode;
        a_sel_t              a_sel;
        logic                b_sel;
        logic [WordSize-1:0] imm;
        logic [RegW-1:0]     rs1;
        logic [RegW-1:0]     rs2;
        logic [RegW-1:0]     rd;
        logic                rd_we;
        logic                illegal;
        logic [WordSize-1:0] pc;
    } dec_t;

    // ALU mode for register/immediate arithmetic from {funct7[5], funct3}
    function automatic logic [ModeW-1:0] op_mode(input logic f7b5, input logic [2:0] f3);
        logic [ModeW-1:0] m;
        case ({f7b5, f3})
            4'b0000: m = ALU_ADD;
            4'b1000: m = ALU_SUB;
            4'b0001: m = ALU_LLS;
            4'b0010: m = ALU_SSLT;
            4'b0011: m = ALU_USLT;
            4'b0100: m = ALU_XOR;
            4'b0101: m = ALU_LRS;
            4'b1101: m = ALU_ARS;
            4'b0110: m = ALU_OR;
            4'b0111: m = ALU_AND;
            default: m = ALU_ADD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational RV32I instruction decode into ALU control payload (dec_t).
module alu_instr_decode
    import alu_pkg::*;
(
    input  logic [31:0]         instr_i,
    input  logic [WordSize-1:0] pc_i,
    output dec_t                dec_o
);

    logic [6:0]          opc;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [WordSize-1:0] imm_i;
    logic [WordSize-1:0] imm_s;
    logic [WordSize-1:0] imm_b;
    logic [WordSize-1:0] imm_u;
    logic [WordSize-1:0] imm_j;
    logic [WordSize-1:0] imm_sh;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    assign imm_i  = {{(WordSize-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{(WordSize-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{(WordSize-13){instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {{(WordSize-32){instr_i[31]}}, instr_i[31:12], 12'b0};
    assign imm_j  = {{(WordSize-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
    // Shift-immediates carry only the shift amount
    assign imm_sh = WordSize'(instr_i[24:20]);

    always_comb begin
        dec_o         = '0;
        dec_o.mode    = ALU_ADD;
        dec_o.a_sel   = A_RS1;
        dec_o.rs1     = instr_i[19:15];
        dec_o.rs2     = instr_i[24:20];
        dec_o.rd      = instr_i[11:7];
        dec_o.pc      = pc_i;
        dec_o.illegal = 1'b0;

        case (opc)
            OPC_OP: begin
                dec_o.mode    = op_mode(f7[5], f3);
                dec_o.rd_we   = 1'b1;
                dec_o.illegal = !((f7 == 7'h00) ||
                                  ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                dec_o.b_sel = 1'b1;
                dec_o.rd_we = 1'b1;
                if (f3 == 3'b001) begin
                    dec_o.mode    = ALU_LLS;
                    dec_o.imm     = imm_sh;
                    dec_o.illegal = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    dec_o.mode    = op_mode(f7[5], f3);
                    dec_o.imm     = imm_sh;
                    dec_o.illegal = !((f7 == 7'h00) || (f7 == 7'h20));
                end else begin
                    dec_o.mode = op_mode(1'b0, f3);
                    dec_o.imm  = imm_i;
                end
            end
            OPC_LUI: begin
                dec_o.a_sel = A_ZERO;
                dec_o.b_sel = 1'b1;
                dec_o.imm   = imm_u;
                dec_o.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.a_sel = A_PC;
                dec_o.b_sel = 1'b1;
                dec_o.imm   = imm_u;
                dec_o.rd_we = 1'b1;
            end
            OPC_JAL: begin
                dec_o.a_sel = A_PC;
                dec_o.b_sel = 1'b1;
                dec_o.imm   = imm_j;
                dec_o.rd_we = 1'b1;
            end
            OPC_JALR, OPC_LOAD: begin
                dec_o.b_sel = 1'b1;
                dec_o.imm   = imm_i;
                dec_o.rd_we = 1'b1;
            end
            OPC_STORE: begin
                dec_o.b_sel = 1'b1;
                dec_o.imm   = imm_s;
            end
            OPC_BRANCH: begin
                dec_o.imm = imm_b;
                case (f3)
                    3'b000, 3'b001: dec_o.mode = ALU_SUB;
                    3'b100, 3'b101: dec_o.mode = ALU_SSLT;
                    3'b110, 3'b111: dec_o.mode = ALU_USLT;
                    default:        dec_o.illegal = 1'b1;
                endcase
            end
            default: dec_o.illegal = 1'b1;
        endcase

        // Illegal instructions travel downstream as an inert ADD
        if (dec_o.illegal) begin
            dec_o.mode  = ALU_ADD;
            dec_o.a_sel = A_RS1;
            dec_o.b_sel = 1'b0;
            dec_o.imm   = '0;
            dec_o.rd_we = 1'b0;
        end
    end

endmodule

// File: rtl/alu_decoder.sv
// Registered RV32I decode stage with valid/ready on both sides and flush.
// Define ALU_DECODER_SKID_EN for a two-entry skid buffer with a registered in_ready.
module alu_decoder
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [WordSize-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ModeW-1:0]    out_alu_mode,
    output logic [1:0]          out_a_sel,
    output logic                out_b_sel,
    output logic [WordSize-1:0] out_imm,
    output logic [RegW-1:0]     out_rs1,
    output logic [RegW-1:0]     out_rs2,
    output logic [RegW-1:0]     out_rd,
    output logic                out_rd_we,
    output logic                out_illegal,
    output logic [WordSize-1:0] out_pc
);

    dec_t dec_c;
    dec_t out_q, out_d;
    logic out_valid_q, out_valid_d;
    logic accept;
    logic out_fire;

    alu_instr_decode u_decode (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .dec_o   (dec_c)
    );

    assign accept   = in_valid & in_ready & ~flush;
    assign out_fire = out_valid_q & out_ready;

`ifdef ALU_DECODER_SKID_EN
    dec_t skid_q, skid_d;
    logic skid_full_q, skid_full_d;
    logic in_ready_q, in_ready_d;

    // Output register backed by one skid entry; in_ready is registered
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            if (out_fire) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_fire) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                skid_d      = dec_c;
                skid_full_d = 1'b1;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = ~skid_full_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
`else
    // Single output register; ready passes straight through from downstream
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec_c;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready = ~out_valid_q | out_ready;
`endif

    assign out_valid    = out_valid_q;
    assign out_alu_mode = out_q.mode;
    assign out_a_sel    = 2'(out_q.a_sel);
    assign out_b_sel    = out_q.b_sel;
    assign out_imm      = out_q.imm;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_rd       = out_q.rd;
    assign out_rd_we    = out_q.rd_we;
    assign out_illegal  = out_q.illegal;
    assign out_pc       = out_q.pc;

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: expected payloads are queued on accept and checked on each out transfer.
module tb_alu_decoder;

`ifdef ALU_DECODER_SKID_EN
    localparam int StallAccepts = 2;
`else
    localparam int StallAccepts = 1;
`endif

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_alu_mode;
    logic [1:0]  out_a_sel;
    logic        out_b_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;
    logic [31:0] out_pc;

    alu_decoder dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_alu_mode (out_alu_mode),
        .out_a_sel    (out_a_sel),
        .out_b_sel    (out_b_sel),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .out_illegal  (out_illegal),
        .out_pc       (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mode, a_sel, b_sel, imm, rs1, rs2, rd, rd_we, illegal, pc}
    logic [88:0] act_w;
    assign act_w = {out_alu_mode, out_a_sel, out_b_sel, out_imm, out_rs1, out_rs2, out_rd,
                    out_rd_we, out_illegal, out_pc};

    logic [88:0] sb[$];
    logic [88:0] cur_exp;
    logic        last_acc;
    int          total;
    int          bad;
    logic [31:0] pc_n;

    function automatic logic [88:0] mk(input logic [4:0] mode, input logic [1:0] a,
                                       input logic b, input logic [31:0] imm,
                                       input logic [31:0] instr, input logic we,
                                       input logic ill, input logic [31:0] pc);
        return {mode, a, b, imm, instr[19:15], instr[24:20], instr[11:7], we, ill, pc};
    endfunction

    // One clock: sample mid-low-phase, score transfers, advance to next falling edge
    task automatic cyc();
        logic [88:0] e;
        #1;
        last_acc = in_valid && in_ready && !flush;
        if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got=%h", act_w);
            end else begin
                e = sb.pop_front();
                if (act_w !== e) begin
                    bad++;
                    $display("FAIL out_payload got=%h exp=%h", act_w, e);
                end
            end
        end
        if (last_acc) sb.push_back(cur_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] instr, input logic [88:0] exp_v);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc_n;
        cur_exp  = exp_v;
        for (int n = 0; n < 50 && !done; n++) begin
            cyc();
            done = last_acc;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL accept_timeout got=0 exp=1 instr=%h", instr);
        end
        in_valid = 1'b0;
        pc_n     = pc_n + 32'd4;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) cyc();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++;
        if (act_w !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", act_w); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_ops();
        out_ready = 1'b1;
        send(32'h002081B3, mk(5'h00, 2'd0, 1'b0, 32'h0, 32'h002081B3, 1'b1, 1'b0, pc_n));
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL add_latency got=%b exp=1", out_valid); end
        send(32'h402081B3, mk(5'h10, 2'd0, 1'b0, 32'h0, 32'h402081B3, 1'b1, 1'b0, pc_n));
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL sub_replace got=%b exp=1", out_valid); end
        drain();
    endtask

    task automatic test_imm_shift();
        out_ready = 1'b1;
        send(32'h40335293, mk(5'h15, 2'd0, 1'b1, 32'h3,        32'h40335293, 1'b1, 1'b0, pc_n));
        send(32'hFFF00093, mk(5'h00, 2'd0, 1'b1, 32'hFFFFFFFF, 32'hFFF00093, 1'b1, 1'b0, pc_n));
        send(32'h123450B7, mk(5'h00, 2'd2, 1'b1, 32'h12345000, 32'h123450B7, 1'b1, 1'b0, pc_n));
        send(32'h00001297, mk(5'h00, 2'd1, 1'b1, 32'h00001000, 32'h00001297, 1'b1, 1'b0, pc_n));
        send(32'hFE20AE23, mk(5'h00, 2'd0, 1'b1, 32'hFFFFFFFC, 32'hFE20AE23, 1'b0, 1'b0, pc_n));
        drain();
    endtask

    task automatic test_branch_illegal();
        out_ready = 1'b1;
        send(32'hFE20ECE3, mk(5'h03, 2'd0, 1'b0, 32'hFFFFFFF8, 32'hFE20ECE3, 1'b0, 1'b0, pc_n));
        send(32'h00002063, mk(5'h00, 2'd0, 1'b0, 32'h0, 32'h00002063, 1'b0, 1'b1, pc_n));
        send(32'h0000007F, mk(5'h00, 2'd0, 1'b0, 32'h0, 32'h0000007F, 1'b0, 1'b1, pc_n));
        send(32'h402091B3, mk(5'h00, 2'd0, 1'b0, 32'h0, 32'h402091B3, 1'b0, 1'b1, pc_n));
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] beats[4];
        logic [88:0] snap;
        int          idx;
        beats[0] = 32'h00100093;
        beats[1] = 32'h00200113;
        beats[2] = 32'h00300193;
        beats[3] = 32'h00400213;
        idx       = 0;
        out_ready = 1'b0;
        snap      = '0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_instr = beats[idx];
            in_pc    = pc_n;
            cur_exp  = mk(5'h00, 2'd0, 1'b1, 32'(idx + 1), beats[idx], 1'b1, 1'b0, pc_n);
            cyc();
            if (last_acc) begin
                idx++;
                pc_n = pc_n + 32'd4;
            end
            if (c == 0) begin
                snap = act_w;
            end else begin
                total++;
                if (act_w !== snap) begin
                    bad++;
                    $display("FAIL stall_stable got=%h exp=%h", act_w, snap);
                end
            end
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (idx != StallAccepts) begin bad++; $display("FAIL stall_accepts got=%0d exp=%0d", idx, StallAccepts); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = idx; k < 4; k++)
            send(beats[k], mk(5'h00, 2'd0, 1'b1, 32'(k + 1), beats[k], 1'b1, 1'b0, pc_n));
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'h00500293, mk(5'h00, 2'd0, 1'b1, 32'h5, 32'h00500293, 1'b1, 1'b0, pc_n));
`ifdef ALU_DECODER_SKID_EN
        send(32'h00600313, mk(5'h00, 2'd0, 1'b1, 32'h6, 32'h00600313, 1'b1, 1'b0, pc_n));
`endif
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00700393;
        in_pc    = pc_n;
        cur_exp  = mk(5'h00, 2'd0, 1'b1, 32'h7, 32'h00700393, 1'b1, 1'b0, pc_n);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        sb.delete();
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) cyc();
        send(32'h00800413, mk(5'h00, 2'd0, 1'b1, 32'h8, 32'h00800413, 1'b1, 1'b0, pc_n));
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'h00900493, mk(5'h00, 2'd0, 1'b1, 32'h9, 32'h00900493, 1'b1, 1'b0, pc_n));
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
        #1;
        rstn = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
        total++;
        if (act_w !== '0) begin bad++; $display("FAIL async_reset_data got=%h exp=0", act_w); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL async_reset_ready got=%b exp=1", in_ready); end
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(32'h402081B3, mk(5'h10, 2'd0, 1'b0, 32'h0, 32'h402081B3, 1'b1, 1'b0, pc_n));
        send(32'hFE20ECE3, mk(5'h03, 2'd0, 1'b0, 32'hFFFFFFF8, 32'hFE20ECE3, 1'b0, 1'b0, pc_n));
        drain();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        pc_n      = 32'h0000_1000;
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        cur_exp   = '0;
        last_acc  = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu_ops();
        test_imm_shift();
        test_branch_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
